// File: rtl/safety_island_pkg.sv
// Shared types for the Safety Island DMA frontend: the job descriptor handed
// from a requester to the 1D DMA backend.
package safety_island_pkg;

  localparam int unsigned DmaAddrWidth = 32;
  localparam int unsigned DmaLenWidth  = 24;

  typedef struct packed {
    logic [DmaAddrWidth-1:0] src;
    logic [DmaAddrWidth-1:0] dst;
    logic [DmaLenWidth-1:0]  len;
  } dma_job_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with registered storage; push on full and pop on empty
// are ignored. Any depth >= 1 is supported.
module fifo_v3 #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 1,
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      wr_ptr_q;
  logic [AddrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]       cnt_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] ptr);
    return (ptr == AddrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/safety_island_dma_sched.sv
// Round-robin scheduler sharing one in-order 1D DMA backend between NumReq
// requesters; an owner FIFO routes each in-order completion back as done_o.
module safety_island_dma_sched
  import safety_island_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = DmaAddrWidth,
  parameter int unsigned TFLenWidth     = DmaLenWidth,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never waits on ready, ready may depend on valid.
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]     req_src_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     req_dst_i,
  input  logic [NumReq-1:0][TFLenWidth-1:0]    req_len_i,
  output logic                                 be_valid_o,
  input  logic                                 be_ready_i,
  output logic [AddrWidth-1:0]                 be_src_o,
  output logic [AddrWidth-1:0]                 be_dst_o,
  output logic [TFLenWidth-1:0]                be_len_o,
  input  logic                                 be_rsp_valid_i,
  output logic [NumReq-1:0]                    done_o,
  output logic [NumReq-1:0]                    reject_o,
  output logic [NumReq-1:0][CntW-1:0]          outstanding_o,
  output logic                                 busy_o
);

  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   win_idx;
  logic              win_found;
  int unsigned       cand;
  logic              accept;
  logic              grant;
  logic              zero_len;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IdxW-1:0]   owner;
  dma_job_t          slot_q;
  logic              slot_valid_q;
  logic [NumReq-1:0] done_q;
  logic [NumReq-1:0] reject_q;
  logic [NumReq-1:0] inc_vec;
  logic [NumReq-1:0] dec_vec;
  logic [NumReq-1:0][CntW-1:0] cnt_q;

  // A pop in the same cycle does not free a full FIFO for a grant.
  assign accept   = rst_ni && (!slot_valid_q || be_ready_i) && !fifo_full;
  assign grant    = accept && win_found;
  assign zero_len = (req_len_i[win_idx] == '0);
  assign push     = grant && !zero_len;
  assign pop      = be_rsp_valid_i && !fifo_empty;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!win_found && req_valid_i[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    inc_vec     = '0;
    dec_vec     = '0;
    if (grant) req_ready_o[win_idx] = 1'b1;
    if (push)  inc_vec[win_idx]     = 1'b1;
    if (pop)   dec_vec[owner]       = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q        <= '0;
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      done_q       <= '0;
      reject_q     <= '0;
    end else begin
      if (grant) ptr_q <= (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + 1'b1;
      if (push) begin
        slot_q.src   <= req_src_i[win_idx];
        slot_q.dst   <= req_dst_i[win_idx];
        slot_q.len   <= req_len_i[win_idx];
        slot_valid_q <= 1'b1;
      end else if (be_ready_i) begin
        slot_valid_q <= 1'b0;
      end
      done_q   <= '0;
      reject_q <= '0;
      if (pop) done_q[owner] <= 1'b1;
      if (grant && zero_len) reject_q[win_idx] <= 1'b1;
    end
  end

  // Push and pop on the same owner cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NumReq; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt_q[r] <= cnt_q[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r]) cnt_q[r] <= cnt_q[r] - 1'b1;
      end
    end
  end

  fifo_v3 #(
    .DEPTH      (MaxOutstanding),
    .DATA_WIDTH (IdxW)
  ) i_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (win_idx),
    .push_i  (push),
    .data_o  (owner),
    .pop_i   (pop)
  );

  assign be_valid_o    = slot_valid_q;
  assign be_src_o      = slot_q.src;
  assign be_dst_o      = slot_q.dst;
  assign be_len_o      = slot_q.len;
  assign done_o        = done_q;
  assign reject_o      = reject_q;
  assign outstanding_o = cnt_q;
  assign busy_o        = !fifo_empty;

endmodule

// File: tb/tb_safety_island_dma_sched.sv
// Directed bench for safety_island_dma_sched: expected grants, issues,
// completions and rejects are queued by the stimulus and checked by a monitor.
module tb_safety_island_dma_sched;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready_o;
  logic [1:0][31:0] req_src;
  logic [1:0][31:0] req_dst;
  logic [1:0][23:0] req_len;
  logic             be_valid_o;
  logic             be_ready;
  logic [31:0]      be_src_o;
  logic [31:0]      be_dst_o;
  logic [23:0]      be_len_o;
  logic             be_rsp_valid;
  logic [1:0]       done_o;
  logic [1:0]       reject_o;
  logic [1:0][2:0]  outstanding_o;
  logic             busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [87:0] exp_issue_q[$];
  logic [1:0]  exp_grant_q[$];
  logic [1:0]  exp_done_q[$];
  logic [1:0]  exp_rej_q[$];

  safety_island_dma_sched dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_src_i      (req_src),
    .req_dst_i      (req_dst),
    .req_len_i      (req_len),
    .be_valid_o     (be_valid_o),
    .be_ready_i     (be_ready),
    .be_src_o       (be_src_o),
    .be_dst_o       (be_dst_o),
    .be_len_o       (be_len_o),
    .be_rsp_valid_i (be_rsp_valid),
    .done_o         (done_o),
    .reject_o       (reject_o),
    .outstanding_o  (outstanding_o),
    .busy_o         (busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  rsp_needs_owner: assert property (@(posedge clk) disable iff (!rst_n) be_rsp_valid |-> busy_o)
    else $error("FAIL rsp_on_empty: response with empty owner FIFO");

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready_o != 2'b00) begin
        if (exp_grant_q.size() == 0) check("grant_unexpected", 128'(req_ready_o), 128'(0));
        else check("grant", 128'(req_ready_o), 128'(exp_grant_q.pop_front()));
      end
      if (be_valid_o && be_ready) begin
        if (exp_issue_q.size() == 0) check("issue_unexpected", 128'({be_src_o, be_dst_o, be_len_o}), 128'(0));
        else check("issue", 128'({be_src_o, be_dst_o, be_len_o}), 128'(exp_issue_q.pop_front()));
      end
      if (done_o != 2'b00) begin
        if (exp_done_q.size() == 0) check("done_unexpected", 128'(done_o), 128'(0));
        else check("done", 128'(done_o), 128'(exp_done_q.pop_front()));
      end
      if (reject_o != 2'b00) begin
        if (exp_rej_q.size() == 0) check("reject_unexpected", 128'(reject_o), 128'(0));
        else check("reject", 128'(reject_o), 128'(exp_rej_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_issue(input logic [31:0] s, input logic [31:0] d, input logic [23:0] l);
    exp_issue_q.push_back({s, d, l});
  endtask

  task automatic send(input int r, input logic [31:0] s, input logic [31:0] d, input logic [23:0] l);
    logic got;
    got        = 1'b0;
    req_src[r] = s;
    req_dst[r] = d;
    req_len[r] = l;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o[r]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("send_timeout", 128'(got), 128'(1));
    tick();
    req_valid[r] = 1'b0;
  endtask

  task automatic respond(input int n);
    be_rsp_valid = 1'b1;
    repeat (n) tick();
    be_rsp_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_src      = '0;
    req_dst      = '0;
    req_len      = '0;
    be_ready     = 1'b0;
    be_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          128'({req_ready_o, be_valid_o, done_o, reject_o, outstanding_o, busy_o,
                be_src_o, be_dst_o, be_len_o}), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // single job from requester 0
    be_ready = 1'b1;
    exp_grant_q.push_back(2'b01);
    push_issue(32'h1000, 32'h2000, 24'd64);
    send(0, 32'h1000, 32'h2000, 24'd64);
    @(negedge clk);
    check("single_valid", 128'(be_valid_o), 128'(1));
    check("single_outstanding", 128'(outstanding_o), 128'({3'd0, 3'd1}));
    repeat (3) tick();
    exp_done_q.push_back(2'b01);
    respond(1);
    @(negedge clk);
    check("single_drained", 128'({outstanding_o, busy_o}), 128'(0));

    // both requesters continuously valid: pointer sits at 1 after the last grant
    req_src[0] = 32'hA000; req_dst[0] = 32'hB000; req_len[0] = 24'd16;
    req_src[1] = 32'hC000; req_dst[1] = 32'hD000; req_len[1] = 24'd32;
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        exp_grant_q.push_back(2'b10);
        exp_done_q.push_back(2'b10);
        push_issue(32'hC000, 32'hD000, 24'd32);
      end else begin
        exp_grant_q.push_back(2'b01);
        exp_done_q.push_back(2'b01);
        push_issue(32'hA000, 32'hB000, 24'd16);
      end
      tick();
      if (i == 0) be_rsp_valid = 1'b1;
    end
    req_valid = 2'b00;
    tick();
    be_rsp_valid = 1'b0;
    @(negedge clk);
    check("rr_drained", 128'({outstanding_o, busy_o}), 128'(0));
    tick();

    // backend stall holds the slot and blocks further grants
    be_ready = 1'b0;
    exp_grant_q.push_back(2'b01);
    send(0, 32'h1111_0000, 32'h2222_0000, 24'd100);
    req_src[1] = 32'h3333_0000; req_dst[1] = 32'h4444_0000; req_len[1] = 24'd200;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold", 128'({be_valid_o, be_src_o, be_dst_o, be_len_o}),
            128'({1'b1, 32'h1111_0000, 32'h2222_0000, 24'd100}));
      check("stall_no_grant", 128'(req_ready_o), 128'(0));
    end
    tick();
    push_issue(32'h1111_0000, 32'h2222_0000, 24'd100);
    exp_grant_q.push_back(2'b10);
    push_issue(32'h3333_0000, 32'h4444_0000, 24'd200);
    be_ready = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("stall_outstanding", 128'(outstanding_o), 128'({3'd1, 3'd1}));
    tick();
    exp_done_q.push_back(2'b01);
    exp_done_q.push_back(2'b10);
    respond(2);

    // owner FIFO full: no grant until a pop, and not in the pop cycle
    for (int i = 0; i < 4; i++) begin
      exp_grant_q.push_back(2'b01);
      push_issue(32'h5000 + 32'(i), 32'h6000, 24'(i + 1));
      send(0, 32'h5000 + 32'(i), 32'h6000, 24'(i + 1));
    end
    check("full_outstanding", 128'(outstanding_o), 128'({3'd0, 3'd4}));
    req_src[0] = 32'h7000; req_dst[0] = 32'h8000; req_len[0] = 24'd9;
    req_valid[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_no_grant", 128'(req_ready_o), 128'(0));
    end
    tick();
    exp_grant_q.push_back(2'b01);
    push_issue(32'h7000, 32'h8000, 24'd9);
    exp_done_q.push_back(2'b01);
    be_rsp_valid = 1'b1;
    @(negedge clk);
    check("full_pop_same_cycle", 128'(req_ready_o), 128'(0));
    tick();
    be_rsp_valid = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("full_refill", 128'({outstanding_o, busy_o}), 128'({3'd0, 3'd4, 1'b1}));
    tick();
    repeat (4) exp_done_q.push_back(2'b01);
    respond(4);
    @(negedge clk);
    check("full_drained", 128'({outstanding_o, busy_o}), 128'(0));
    tick();

    // zero-length descriptor from requester 1
    exp_grant_q.push_back(2'b10);
    exp_rej_q.push_back(2'b10);
    send(1, 32'h9000, 32'h9100, 24'd0);
    @(negedge clk);
    check("reject_no_issue", 128'({be_valid_o, outstanding_o, busy_o}), 128'(0));
    tick();

    // reset with jobs in flight
    for (int i = 0; i < 4; i++) begin
      exp_grant_q.push_back(2'b10);
      if (i < 3) push_issue(32'hE000 + 32'(i), 32'hF000, 24'd8);
      send(1, 32'hE000 + 32'(i), 32'hF000, 24'd8);
    end
    be_ready   = 1'b0;
    req_src[0] = 32'h0ABC; req_dst[0] = 32'h0DEF; req_len[0] = 24'd4;
    req_valid  = 2'b11;
    @(negedge clk);
    check("pre_reset_state", 128'({outstanding_o, req_ready_o, be_valid_o, busy_o}),
          128'({3'd4, 3'd0, 2'b00, 1'b1, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs",
          128'({req_ready_o, be_valid_o, done_o, reject_o, outstanding_o, busy_o}), 128'(0));
    tick();
    tick();
    exp_grant_q.push_back(2'b01);
    push_issue(32'h0ABC, 32'h0DEF, 24'd4);
    be_ready = 1'b1;
    rst_n    = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    exp_done_q.push_back(2'b01);
    respond(1);
    @(negedge clk);
    check("post_reset_drained", 128'({outstanding_o, busy_o}), 128'(0));

    repeat (3) tick();
    check("grant_q_empty", 128'(exp_grant_q.size()), 128'(0));
    check("issue_q_empty", 128'(exp_issue_q.size()), 128'(0));
    check("done_q_empty", 128'(exp_done_q.size()), 128'(0));
    check("reject_q_empty", 128'(exp_rej_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
